fb_display_unit: RTL

//  Datapath-side executor for DISPLAY instructions issued by the framebuffer display sequencer.

---
 rtl/fb_display_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fb_display_unit.sv
// Executes DISPLAY instructions: reads one framebuffer pixel and forwards it to the VGA adapter as a single plot.
// Define FB_DISPLAY_UNIT_CLIP_EN to reject off-screen coordinates instead of plotting them raw.
//
// state  | meaning
// IDLE   | waiting for an armed start
// ADDR   | compute framebuffer address from latched x/y
// RDWAIT | RAM samples fb_addr
// PLOT   | capture pixel, raise vga_plot, update result
// DONE   | drop vga_plot, raise finished
module fb_display_unit #(
    parameter int                INSTR_W  = 32,
    parameter int                OPC_W    = 4,
    parameter logic [OPC_W-1:0]  OPC_DISP = OPC_W'(3),
    parameter int                X_W      = 8,
    parameter int                Y_W      = 7,
    parameter int                SCR_W    = 160,
    parameter int                SCR_H    = 120,
    parameter int                COL_W    = 3,
    parameter int                ADDR_W   = 15,
    parameter int                RES_W    = 32,
    parameter logic [RES_W-1:0]  ERR_CODE = '1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic               finished,
    output logic [RES_W-1:0]   result,
    output logic [ADDR_W-1:0]  fb_addr,
    input  logic [COL_W-1:0]   fb_rdata,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COL_W-1:0]   vga_colour,
    output logic               vga_plot
);

    typedef enum logic [2:0] {IDLE, ADDR, RDWAIT, PLOT, DONE} state_t;

    state_t           state, state_next;
    logic             armed;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;

    logic [OPC_W-1:0] opc_in;
    logic [X_W-1:0]   x_in;
    logic [Y_W-1:0]   y_in;
    logic             launch;
    logic             in_range;
    logic             accept;
    logic [ADDR_W-1:0] addr_calc;
    logic             unused_pad;

    assign opc_in     = instruction[INSTR_W-1 -: OPC_W];
    assign x_in       = instruction[X_W-1:0];
    assign y_in       = instruction[X_W+Y_W-1:X_W];
    assign unused_pad = ^instruction[INSTR_W-OPC_W-1:X_W+Y_W];

`ifdef FB_DISPLAY_UNIT_CLIP_EN
    localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCR_W);
    localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCR_H);
    assign in_range = ({1'b0, x_in} < SCR_W_L) && ({1'b0, y_in} < SCR_H_L);
`else
    assign in_range = 1'b1;
`endif

    assign launch = (state == IDLE) && armed && start;
    assign accept = (opc_in == OPC_DISP) && in_range;

    // y*160 as shift-add; only valid while SCR_W is 160
    assign addr_calc = (ADDR_W'(y_q) << 7) + (ADDR_W'(y_q) << 5) + ADDR_W'(x_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = accept ? ADDR : DONE;
            ADDR:    state_next = RDWAIT;
            RDWAIT:  state_next = PLOT;
            PLOT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed      <= 1'b1;
            finished   <= 1'b1;
            result     <= '0;
            fb_addr    <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            // a start held high launches once; it must drop before the next launch
            if (!start) armed <= 1'b1;
            if (launch) begin
                armed    <= 1'b0;
                finished <= 1'b0;
                x_q      <= x_in;
                y_q      <= y_in;
                if (!accept) result <= ERR_CODE;
            end
            case (state)
                ADDR: fb_addr <= addr_calc;
                PLOT: begin
                    vga_x      <= x_q;
                    vga_y      <= y_q;
                    vga_colour <= fb_rdata;
                    vga_plot   <= 1'b1;
                    result     <= RES_W'(fb_rdata);
                end
                DONE: begin
                    vga_plot <= 1'b0;
                    finished <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
